// File: rtl/data_mem_bridge.sv
// data_mem_bridge: CPU data port to synchronous word-wide SRAM bridge.
// Each request is latched, issued to the SRAM once, and answered after a
// fixed number of wait states. Stores are lane-replicated and loads are
// right-aligned to the byte address. Illegal accesses skip the SRAM and
// set a sticky error flag.
module data_mem_bridge #(
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic [3:0]        cpu_write,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_cs,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e state_q, state_d;

  logic              request;
  logic              is_store;
  logic              both_set;
  logic              strobe_ok;
  logic              addr_ok;
  logic              illegal;
  logic [31:0]       fmt_wdata;

  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        we_q;
  logic              store_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic [3:0]        cnt_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [15:0]       rd_count_q;
  logic [15:0]       wr_count_q;

  assign request  = cpu_read | (|cpu_write);
  assign is_store = |cpu_write;
  assign both_set = cpu_read & is_store;
  assign addr_ok  = (cpu_addr[31:ADDR_W+2] == '0);
  assign illegal  = (is_store & ~strobe_ok) | ~addr_ok;

  // Classify the store strobe and replicate sub-word data onto every lane
  always_comb begin
    strobe_ok = 1'b0;
    fmt_wdata = cpu_wdata;
    case (cpu_write)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
        strobe_ok = 1'b1;
        fmt_wdata = {4{cpu_wdata[7:0]}};
      end
      4'b0011, 4'b1100: begin
        strobe_ok = 1'b1;
        fmt_wdata = {2{cpu_wdata[15:0]}};
      end
      4'b1111: begin
        strobe_ok = 1'b1;
        fmt_wdata = cpu_wdata;
      end
      default: begin
        strobe_ok = 1'b0;
        fmt_wdata = cpu_wdata;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: illegal requests go straight to DONE, stores skip WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (request) state_d = illegal ? S_DONE : S_ISSUE;
      S_ISSUE: state_d = store_q ? S_DONE : S_WAIT;
      S_WAIT:  if (cnt_q == 4'(WAIT_CYCLES - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the request when it is accepted out of IDLE; later changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= '0;
      store_q <= 1'b0;
      off_q   <= '0;
      wdata_q <= '0;
    end else if (state_q == S_IDLE && request) begin
      addr_q  <= cpu_addr[ADDR_W+1:2];
      we_q    <= cpu_write;
      store_q <= is_store;
      off_q   <= cpu_addr[1:0];
      wdata_q <= fmt_wdata;
    end
  end

  // Wait-state counter, cleared while the access is being issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt_q <= '0;
    else if (state_q == S_ISSUE) cnt_q <= '0;
    else if (state_q == S_WAIT)  cnt_q <= cnt_q + 4'd1;
  end

  // Load data: capture and align at the end of WAIT, zero for an illegal load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state_q == S_WAIT && state_d == S_DONE) begin
      rdata_q <= mem_rdata >> {off_q, 3'b000};
    end else if (state_q == S_IDLE && request && illegal && !is_store) begin
      rdata_q <= '0;
    end
  end

  // Sticky error on an illegal request or a simultaneous load and store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if (state_q == S_IDLE && request && (illegal || both_set)) err_q <= 1'b1;
  end

  // Access counters bump on entry to DONE for legal accesses only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if (state_q == S_WAIT && state_d == S_DONE) rd_count_q <= rd_count_q + 16'd1;
      if (state_q == S_ISSUE && store_q)          wr_count_q <= wr_count_q + 16'd1;
    end
  end

  // Outputs: one chip-select cycle in ISSUE, stall until DONE
  always_comb begin
    mem_cs    = (state_q == S_ISSUE);
    mem_we    = mem_cs ? we_q : 4'b0000;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    cpu_rdata = rdata_q;
    err       = err_q;
    rd_count  = rd_count_q;
    wr_count  = wr_count_q;
    cpu_stall = request && (state_q != S_DONE) && !rst;
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb_data_mem_bridge: directed vector bench for data_mem_bridge with a
// small synchronous SRAM model behind the bridge.
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_read = 1'b0;
  logic [3:0]  cpu_write = 4'b0000;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_cs;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  int          csCount = 0;
  logic [13:0] csAddr;
  logic [3:0]  csWe;
  logic [31:0] csWdata;

  logic [31:0] sram [0:16383];

  typedef struct {
    string       name;
    bit          rd;
    logic [3:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          expStalls;
    int          expCs;
    logic [13:0] expMemAddr;
    logic [3:0]  expWe;
    bit          chkWd;
    logic [31:0] expMemWdata;
    bit          chkRd;
    logic [31:0] expRdata;
    bit          expErr;
  } vec_t;

  vec_t vecs[$];

  data_mem_bridge #(.ADDR_W(14), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .err       (err),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Synchronous SRAM: byte-lane writes and a registered read on chip select
  always @(posedge clk) begin
    if (mem_cs) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= sram[mem_addr];
    end
  end

  // Record every chip-select cycle the bridge produces
  always @(negedge clk) begin
    if (mem_cs) begin
      csCount = csCount + 1;
      csAddr  = mem_addr;
      csWe    = mem_we;
      csWdata = mem_wdata;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic addVec(input string n, input bit rd, input logic [3:0] wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int st, input int cs, input logic [13:0] ma,
                        input logic [3:0] we, input bit cw, input logic [31:0] mwd, input bit cr,
                        input logic [31:0] rdv, input bit e);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wd;
    v.expStalls = st; v.expCs = cs; v.expMemAddr = ma; v.expWe = we;
    v.chkWd = cw; v.expMemWdata = mwd; v.chkRd = cr; v.expRdata = rdv; v.expErr = e;
    vecs.push_back(v);
  endtask

  // Present one request, count stall cycles up to the first unstalled cycle,
  // sample the load data there, then drop the request
  task automatic applyStimulus(input bit rd, input logic [3:0] wr, input logic [31:0] addr,
                               input logic [31:0] wd, output int stalls,
                               output logic [31:0] rdata, output bit timedOut);
    @(posedge clk); #1;
    csCount   = 0;
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wd;
    stalls    = 0;
    timedOut  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!cpu_stall) begin
        timedOut = 1'b0;
        break;
      end
      stalls = stalls + 1;
      @(posedge clk); #1;
    end
    rdata = cpu_rdata;
    @(posedge clk); #1;
    cpu_read  = 1'b0;
    cpu_write = 4'b0000;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
  endtask

  initial begin
    int          stalls;
    logic [31:0] rdata;
    bit          timedOut;
    int          expRd;
    int          expWr;
    vec_t        v;

    expRd = 0;
    expWr = 0;

    addVec("st_word",   0, 4'hF, 32'h10, 32'hDEADBEEF, 2, 1, 14'd4, 4'hF, 1, 32'hDEADBEEF, 0, 32'h0, 0);
    addVec("ld_word",   1, 4'h0, 32'h10, 32'h0,        4, 1, 14'd4, 4'h0, 0, 32'h0, 1, 32'hDEADBEEF, 0);
    addVec("st_base",   0, 4'hF, 32'h10, 32'h11223344, 2, 1, 14'd4, 4'hF, 1, 32'h11223344, 0, 32'h0, 0);
    addVec("st_byte",   0, 4'h8, 32'h13, 32'h000000A5, 2, 1, 14'd4, 4'h8, 1, 32'hA5A5A5A5, 0, 32'h0, 0);
    addVec("ld_byte3",  1, 4'h0, 32'h13, 32'h0,        4, 1, 14'd4, 4'h0, 0, 32'h0, 1, 32'h000000A5, 0);
    addVec("ld_word2",  1, 4'h0, 32'h10, 32'h0,        4, 1, 14'd4, 4'h0, 0, 32'h0, 1, 32'hA5223344, 0);
    addVec("ld_off1",   1, 4'h0, 32'h11, 32'h0,        4, 1, 14'd4, 4'h0, 0, 32'h0, 1, 32'h00A52233, 0);
    addVec("st_clr20",  0, 4'hF, 32'h20, 32'h0,        2, 1, 14'd8, 4'hF, 1, 32'h0, 0, 32'h0, 0);
    addVec("st_half",   0, 4'hC, 32'h22, 32'h0000BEEF, 2, 1, 14'd8, 4'hC, 1, 32'hBEEFBEEF, 0, 32'h0, 0);
    addVec("ld_half",   1, 4'h0, 32'h22, 32'h0,        4, 1, 14'd8, 4'h0, 0, 32'h0, 1, 32'h0000BEEF, 0);
    addVec("ld_word8",  1, 4'h0, 32'h20, 32'h0,        4, 1, 14'd8, 4'h0, 0, 32'h0, 1, 32'hBEEF0000, 0);
    addVec("st_clr24",  0, 4'hF, 32'h24, 32'h0,        2, 1, 14'd9, 4'hF, 1, 32'h0, 0, 32'h0, 0);
    addVec("st_lohalf", 0, 4'h3, 32'h24, 32'h00005678, 2, 1, 14'd9, 4'h3, 1, 32'h56785678, 0, 32'h0, 0);
    addVec("st_byte1",  0, 4'h2, 32'h25, 32'h000000AB, 2, 1, 14'd9, 4'h2, 1, 32'hABABABAB, 0, 32'h0, 0);
    addVec("ld_off1b",  1, 4'h0, 32'h25, 32'h0,        4, 1, 14'd9, 4'h0, 0, 32'h0, 1, 32'h000000AB, 0);
    addVec("st_bad",    0, 4'h5, 32'h30, 32'h1,        1, 0, 14'd0, 4'h0, 0, 32'h0, 0, 32'h0, 1);
    addVec("ld_range",  1, 4'h0, 32'h00010000, 32'h0,  1, 0, 14'd0, 4'h0, 0, 32'h0, 1, 32'h0, 1);
    addVec("st_hiaddr", 0, 4'hF, 32'h80000000, 32'h7,  1, 0, 14'd0, 4'h0, 0, 32'h0, 0, 32'h0, 1);
    addVec("ld_after",  1, 4'h0, 32'h10, 32'h0,        4, 1, 14'd4, 4'h0, 0, 32'h0, 1, 32'hA5223344, 1);

    // Reset state and idle behaviour
    #2;
    checkOutput("rst_stall", {31'h0, cpu_stall}, 32'h0);
    checkOutput("rst_cs",    {31'h0, mem_cs}, 32'h0);
    checkOutput("rst_rdata", cpu_rdata, 32'h0);
    checkOutput("rst_err",   {31'h0, err}, 32'h0);
    checkOutput("rst_cnt",   {rd_count, wr_count}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    csCount = 0;
    repeat (3) @(negedge clk);
    checkOutput("idle_stall", {31'h0, cpu_stall}, 32'h0);
    checkOutput("idle_cs",    csCount, 32'd0);

    // Table-driven vectors
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      applyStimulus(v.rd, v.wr, v.addr, v.wdata, stalls, rdata, timedOut);
      checkOutput({v.name, "_timeout"}, {31'h0, timedOut}, 32'h0);
      checkOutput({v.name, "_stalls"}, stalls, v.expStalls);
      checkOutput({v.name, "_cs"}, csCount, v.expCs);
      if (v.expCs != 0) begin
        checkOutput({v.name, "_maddr"}, {18'h0, csAddr}, {18'h0, v.expMemAddr});
        checkOutput({v.name, "_we"}, {28'h0, csWe}, {28'h0, v.expWe});
        if (v.wr != 4'h0) expWr = expWr + 1;
        else              expRd = expRd + 1;
      end
      if (v.chkWd) checkOutput({v.name, "_mwdata"}, csWdata, v.expMemWdata);
      if (v.chkRd) checkOutput({v.name, "_rdata"}, rdata, v.expRdata);
      checkOutput({v.name, "_err"}, {31'h0, err}, {31'h0, v.expErr});
      checkOutput({v.name, "_rdcnt"}, {16'h0, rd_count}, 32'(expRd));
      checkOutput({v.name, "_wrcnt"}, {16'h0, wr_count}, 32'(expWr));
    end

    // Reset in the middle of a load's WAIT phase
    @(posedge clk); #1;
    cpu_read = 1'b1;
    cpu_addr = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("wrst_stall", {31'h0, cpu_stall}, 32'h0);
    checkOutput("wrst_cs",    {31'h0, mem_cs}, 32'h0);
    checkOutput("wrst_rdata", cpu_rdata, 32'h0);
    checkOutput("wrst_cnt",   {rd_count, wr_count}, 32'h0);
    checkOutput("wrst_err",   {31'h0, err}, 32'h0);
    checkOutput("wrst_mem",   {mem_we, 14'h0, mem_addr}, 32'h0);
    checkOutput("wrst_mwd",   mem_wdata, 32'h0);
    cpu_read = 1'b0;
    cpu_addr = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 4'h0, 32'h10, 32'h0, stalls, rdata, timedOut);
    checkOutput("post_rst_stalls", stalls, 32'd4);
    checkOutput("post_rst_rdata",  rdata, 32'hA5223344);
    checkOutput("post_rst_rdcnt",  {16'h0, rd_count}, 32'd1);

    // A store cut off by reset in ISSUE must not reach the SRAM
    applyStimulus(1'b0, 4'hF, 32'h40, 32'h11111111, stalls, rdata, timedOut);
    @(posedge clk); #1;
    csCount   = 0;
    cpu_write = 4'hF;
    cpu_addr  = 32'h40;
    cpu_wdata = 32'h12345678;
    @(posedge clk); #1;
    rst       = 1'b1;
    cpu_write = 4'h0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    @(negedge clk);
    checkOutput("abort_cs", csCount, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 4'h0, 32'h40, 32'h0, stalls, rdata, timedOut);
    checkOutput("abort_rdata", rdata, 32'h11111111);
    checkOutput("abort_wrcnt", {16'h0, wr_count}, 32'd0);

    // Load and store together: performed as a store, error flagged
    applyStimulus(1'b1, 4'hF, 32'h50, 32'h0BADF00D, stalls, rdata, timedOut);
    checkOutput("both_stalls", stalls, 32'd2);
    checkOutput("both_we",     {28'h0, csWe}, 32'hF);
    checkOutput("both_err",    {31'h0, err}, 32'h1);
    checkOutput("both_wrcnt",  {16'h0, wr_count}, 32'd1);
    applyStimulus(1'b1, 4'h0, 32'h50, 32'h0, stalls, rdata, timedOut);
    checkOutput("both_rdata",  rdata, 32'h0BADF00D);

    // Read counter wrap, starting just below the top
    @(posedge clk); #1;
    force dut.rd_count_q = 16'hFFFE;
    #1;
    release dut.rd_count_q;
    applyStimulus(1'b1, 4'h0, 32'h10, 32'h0, stalls, rdata, timedOut);
    checkOutput("wrap_ffff", {16'h0, rd_count}, 32'h0000FFFF);
    applyStimulus(1'b1, 4'h0, 32'h10, 32'h0, stalls, rdata, timedOut);
    checkOutput("wrap_zero", {16'h0, rd_count}, 32'h0);
    checkOutput("wrap_rdata", rdata, 32'hA5223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
